// File: rtl/da_tap_serializer.sv
// Bit-serial tap serializer for a distributed-arithmetic FIR engine.
// Holds a TAPS-deep delay line of DATA_W-bit samples. For each new sample it
// presents DATA_W LUT addresses, one per bit slice. Bit k of each address is
// bit bit_idx of tap k. Slices run LSB first, and the sign slice is last.
module da_tap_serializer #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 8
) (
    input  logic                      clk3,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_sample,
    output logic                      in_ready,
    output logic [TAPS-1:0]           lut_addr,
    output logic                      addr_valid,
    input  logic                      addr_ready,
    output logic [$clog2(DATA_W)-1:0] bit_idx,
    output logic                      addr_first,
    output logic                      addr_last
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SER  = 1'b1
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] tap_reg [TAPS];

    logic in_ser;
    logic at_last;
    logic accept;
    logic advance;

    assign in_ser  = (state_reg == SER);
    assign at_last = (cnt_reg == CNT_LAST);

    // A new sample is taken while idle. It is also taken in the same cycle
    // that the sign slice is consumed, which gives back-to-back operation.
    // A pending flush blocks any accept.
    assign in_ready = !clear && (!in_ser || (at_last && addr_ready));
    assign accept   = in_valid && in_ready;
    assign advance  = in_ser && addr_ready;

    // Sequencer: IDLE/SER control and the bit-slice counter.
    // clear takes priority over accept and advance.
    always_ff @(posedge clk3 or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else if (clear) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else if (accept) begin
            state_reg <= SER;
            cnt_reg   <= '0;
        end else if (advance) begin
            if (at_last) begin
                state_reg <= IDLE;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    // Delay line: on an accept, shift toward older taps. The samples are
    // stored raw, and the engine applies the sign weighting on addr_last.
    always_ff @(posedge clk3 or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                tap_reg[k] <= '0;
            end
        end else if (clear) begin
            for (int k = 0; k < TAPS; k++) begin
                tap_reg[k] <= '0;
            end
        end else if (accept) begin
            tap_reg[0] <= in_sample;
            for (int k = 1; k < TAPS; k++) begin
                tap_reg[k] <= tap_reg[k-1];
            end
        end
    end

    // Address slice: one bit from each tap at the current bit position,
    // forced to zero while idle.
    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_slice
            assign lut_addr[gi] = in_ser & tap_reg[gi][cnt_reg];
        end
    endgenerate

    assign addr_valid = in_ser;
    assign bit_idx    = in_ser ? cnt_reg : '0;
    assign addr_first = in_ser && (cnt_reg == '0);
    assign addr_last  = in_ser && at_last;

endmodule

// File: tb/tb_da_tap_serializer.sv
// Testbench for da_tap_serializer. A delay-line model predicts every slice
// at the time a sample is accepted. Observed handshakes are queued, and each
// scenario pops the expected and observed queues and compares them.
module tb_da_tap_serializer;

    localparam int DW = 8;
    localparam int TP = 8;
    localparam int CW = 3;

    logic          clk3 = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_sample = '0;
    logic          in_ready;
    logic [TP-1:0] lut_addr;
    logic          addr_valid;
    logic          addr_ready = 1'b0;
    logic [CW-1:0] bit_idx;
    logic          addr_first;
    logic          addr_last;

    da_tap_serializer #(.DATA_W(DW), .TAPS(TP)) dut (
        .clk3       (clk3),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_sample  (in_sample),
        .in_ready   (in_ready),
        .lut_addr   (lut_addr),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .bit_idx    (bit_idx),
        .addr_first (addr_first),
        .addr_last  (addr_last)
    );

    always #5 clk3 = ~clk3;

    typedef struct packed {
        logic [TP-1:0] lut;
        logic [CW-1:0] idx;
        logic          first;
        logic          last;
    } slice_t;

    slice_t        exp_q[$];
    slice_t        obs_q[$];
    logic [DW-1:0] model_tap [TP];
    int            tests_run = 0;
    int            tests_failed = 0;

    task automatic model_flush();
        for (int k = 0; k < TP; k++) model_tap[k] = '0;
        exp_q.delete();
        obs_q.delete();
    endtask

    // Called on the falling edge after the inputs are set. It records this
    // cycle's handshake and accept, then steps to the next falling edge.
    task automatic tick(output bit acc);
        slice_t s;
        #1;
        acc = 1'b0;
        if (!reset && !clear) begin
            if (addr_valid && addr_ready) begin
                s.lut = lut_addr; s.idx = bit_idx; s.first = addr_first; s.last = addr_last;
                obs_q.push_back(s);
            end
            if (in_valid && in_ready) begin
                acc = 1'b1;
                for (int k = TP - 1; k > 0; k--) model_tap[k] = model_tap[k-1];
                model_tap[0] = in_sample;
                for (int b = 0; b < DW; b++) begin
                    for (int k = 0; k < TP; k++) s.lut[k] = model_tap[k][b];
                    s.idx = CW'(b); s.first = (b == 0); s.last = (b == DW - 1);
                    exp_q.push_back(s);
                end
            end
        end else begin
            model_flush();
        end
        @(negedge clk3);
    endtask

    task automatic do_reset();
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; addr_ready = 1'b1;
        @(negedge clk3); @(negedge clk3);
        reset = 1'b0;
        model_flush();
    endtask

    task automatic test_reset();
        bit acc;
        slice_t o, e;
        @(negedge clk3); #1;
        tests_run++;
        if ({in_ready, addr_valid, lut_addr, bit_idx, addr_first, addr_last} !== {1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rdy=%b v=%b a=%h i=%0d f=%b l=%b, expected 1 0 00 0 0 0", in_ready, addr_valid, lut_addr, bit_idx, addr_first, addr_last);
        end
        reset = 1'b0; model_flush();
        @(negedge clk3);
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_ready: got %b, expected 1", in_ready); end
        addr_ready = 1'b1; in_valid = 1'b1; in_sample = 8'h5A;
        tick(acc); in_valid = 1'b0;
        tick(acc); tick(acc);
        // Assert reset between clock edges; the outputs must clear at once.
        #2 reset = 1'b1; #1;
        tests_run++;
        if ({in_ready, addr_valid, lut_addr, bit_idx, addr_first, addr_last} !== {1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL async_reset: got rdy=%b v=%b a=%h i=%0d f=%b l=%b, expected 1 0 00 0 0 0", in_ready, addr_valid, lut_addr, bit_idx, addr_first, addr_last);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL reset_pre_slice: got %h, expected %h", o, e); end
        end
        @(negedge clk3);
        reset = 1'b0; model_flush();
        @(negedge clk3);
    endtask

    task automatic test_single();
        bit acc;
        slice_t o, e;
        logic [7:0] tbl [8] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        do_reset();
        in_valid = 1'b1; in_sample = 8'h81;
        tick(acc); in_valid = 1'b0;
        tests_run++;
        if ({acc, addr_valid, addr_first} !== 3'b111) begin tests_failed++; $display("FAIL single_latency: got acc/valid/first=%b%b%b, expected 111", acc, addr_valid, addr_first); end
        for (int t = 0; t < DW; t++) tick(acc);
        tests_run++;
        if (addr_valid !== 1'b0) begin tests_failed++; $display("FAIL single_idle: got valid=%b, expected 0", addr_valid); end
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); tests_run += 2;
            if (o !== e) begin tests_failed++; $display("FAIL single_slice%0d: got %h, expected %h", i, o, e); end
            if (o.lut !== tbl[i & 7]) begin tests_failed++; $display("FAIL single_addr%0d: got %h, expected %h", i, o.lut, tbl[i & 7]); end
        end
        tests_run++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin tests_failed++; $display("FAIL single_count: got %0d left, expected %0d left", obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit acc;
        slice_t o, e;
        logic [7:0] tbl [8] = '{8'h03, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02};
        do_reset();
        in_valid = 1'b1; in_sample = 8'h81;
        tick(acc); in_valid = 1'b0;
        for (int t = 0; t < DW - 1; t++) tick(acc);
        in_valid = 1'b1; in_sample = 8'h7F; #1;
        tests_run++;
        if ({in_ready, addr_last} !== 2'b11) begin tests_failed++; $display("FAIL b2b_ready: got ready/last=%b%b, expected 11", in_ready, addr_last); end
        tick(acc); in_valid = 1'b0;
        tests_run++;
        if ({acc, addr_valid, addr_first} !== 3'b111) begin tests_failed++; $display("FAIL b2b_no_gap: got acc/valid/first=%b%b%b, expected 111", acc, addr_valid, addr_first); end
        for (int t = 0; t < DW; t++) tick(acc);
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL b2b_slice%0d: got %h, expected %h", i, o, e); end
            if (i >= 8) begin
                tests_run++;
                if (o.lut !== tbl[i - 8]) begin tests_failed++; $display("FAIL b2b_addr%0d: got %h, expected %h", i - 8, o.lut, tbl[i - 8]); end
            end
        end
        tests_run++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin tests_failed++; $display("FAIL b2b_count: got %0d left, expected %0d left", obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_stall();
        bit acc;
        slice_t o, e;
        do_reset();
        in_valid = 1'b1; in_sample = 8'hB6;
        tick(acc); in_valid = 1'b0;
        for (int t = 0; t < 4; t++) tick(acc);
        addr_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            #1; tests_run++;
            if ({addr_valid, in_ready, bit_idx, lut_addr} !== {1'b1, 1'b0, 3'd4, 8'h01}) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: got v=%b rdy=%b i=%0d a=%h, expected 1 0 4 01", t, addr_valid, in_ready, bit_idx, lut_addr);
            end
            tick(acc);
        end
        addr_ready = 1'b1;
        for (int t = 0; t < 4; t++) tick(acc);
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL stall_slice%0d: got %h, expected %h", i, o, e); end
        end
        tests_run++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin tests_failed++; $display("FAIL stall_count: got %0d left, expected %0d left", obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_fill();
        bit got;
        slice_t o, e;
        logic [7:0] two = 8'd2;
        do_reset();
        for (int s = 1; s <= 9; s++) begin
            in_valid = 1'b1; in_sample = DW'(s); got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) tick(got);
            if (!got) begin tests_run++; tests_failed++; $display("FAIL fill_accept%0d: got no accept, expected accept within 20 cycles", s); end
        end
        in_valid = 1'b0; #1;
        tests_run++;
        if ({addr_first, lut_addr} !== {1'b1, 8'h55}) begin tests_failed++; $display("FAIL fill_slice0: got first=%b a=%h, expected 1 55", addr_first, lut_addr); end
        for (int t = 0; t < DW; t++) tick(got);
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL fill_slice%0d: got %h, expected %h", i, o, e); end
            if (i >= 64) begin
                tests_run++;
                if (o.lut[7] !== two[i - 64]) begin tests_failed++; $display("FAIL fill_tap7_bit%0d: got %b, expected %b", i - 64, o.lut[7], two[i - 64]); end
            end
        end
        tests_run++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin tests_failed++; $display("FAIL fill_count: got %0d left, expected %0d left", obs_q.size(), exp_q.size()); end
    endtask

    // Abort at cnt=3 with clear (use_reset=0) or reset (use_reset=1), then
    // send a fresh 0x01 into what must be an empty line.
    task automatic test_abort(input bit use_reset);
        bit acc;
        slice_t o, e;
        do_reset();
        in_valid = 1'b1; in_sample = 8'h5A;
        tick(acc); in_valid = 1'b0;
        for (int t = 0; t < 3; t++) tick(acc);
        if (use_reset) reset = 1'b1;
        else begin clear = 1'b1; in_valid = 1'b1; in_sample = 8'hFF; end
        #1; tests_run++;
        if (in_ready !== use_reset) begin tests_failed++; $display("FAIL abort%0d_ready: got %b, expected %b", use_reset, in_ready, use_reset); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL abort%0d_pre_slice: got %h, expected %h", use_reset, o, e); end
        end
        tick(acc);
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; #1;
        tests_run++;
        if (addr_valid !== 1'b0) begin tests_failed++; $display("FAIL abort%0d_valid: got %b, expected 0", use_reset, addr_valid); end
        in_valid = 1'b1; in_sample = 8'h01;
        tick(acc); in_valid = 1'b0;
        tests_run++;
        if ({acc, addr_valid, addr_first, lut_addr} !== {3'b111, 8'h01}) begin
            tests_failed++;
            $display("FAIL abort%0d_next: got acc/valid/first=%b%b%b a=%h, expected 111 01", use_reset, acc, addr_valid, addr_first, lut_addr);
        end
        for (int t = 0; t < DW; t++) tick(acc);
        for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); tests_run++;
            if (o !== e) begin tests_failed++; $display("FAIL abort%0d_slice%0d: got %h, expected %h", use_reset, i, o, e); end
        end
        tests_run++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin tests_failed++; $display("FAIL abort%0d_count: got %0d left, expected %0d left", use_reset, obs_q.size(), exp_q.size()); end
    endtask

    initial begin
        model_flush();
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_fill();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
